// File: rtl/trace_pkg.sv
// trace_pkg: width helpers and FIFO entry layout ({ts, payload}) for the trace collector
package trace_pkg;
  function automatic int log2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) ;
    return r;
  endfunction
  function automatic int id_w(input int tiles);
    return (log2(tiles) > 1) ? log2(tiles) : 1;
  endfunction
  function automatic int entry_w(input int fpay, input int tsw);
    return fpay + tsw;
  endfunction
  function automatic int ts_lsb(input int fpay);
    return fpay;
  endfunction
endpackage

// File: rtl/trace_chan_fifo.sv
// trace_chan_fifo: per-channel FIFO with wrap-bit pointers; a push is visible only next cycle
module trace_chan_fifo
  import trace_pkg::*;
#(
  parameter int W     = 48,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = log2(DEPTH);
  localparam logic [AW:0] INC = 1;
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic [W-1:0] mem_q [DEPTH];
  assign empty = wp_q == rp_q;
  assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign dout  = mem_q[rp_q[AW-1:0]];
  always_comb begin
    wp_d = (push && !full) ? wp_q + INC : wp_q;
    rp_d = (pop && !empty) ? rp_q + INC : rp_q;
  end
  always_ff @(posedge clk)
    if (push && !full) mem_q[wp_q[AW-1:0]] <= din;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
endmodule

// File: rtl/trace_collector.sv
// trace_collector: per-tile trace FIFOs drained round-robin into one timestamped valid/ready stream
module trace_collector
  import trace_pkg::*;
#(
  parameter int Fpay       = 32,
  parameter int Tile_num   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TSw        = 16,
  parameter int DROP_CNTw  = 8,
  localparam int IDw       = id_w(Tile_num)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [Tile_num*Fpay-1:0]      din_all,
  input  logic [Tile_num-1:0]           wr_all,
  input  logic [Tile_num-1:0]           ip_mask,
  output logic [Fpay-1:0]               dout,
  output logic [IDw-1:0]                dout_id,
  output logic [TSw-1:0]                dout_ts,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic [Tile_num*DROP_CNTw-1:0] drop_cnt_all,
  input  logic                          clear_drops
);
  localparam int EW  = entry_w(Fpay, TSw);
  localparam int TSL = ts_lsb(Fpay);
  logic [Tile_num-1:0] wen, push, pop, full, empty;
  logic [EW-1:0] fdata [Tile_num];
  logic [TSw-1:0] ts_q, ts_d, dout_ts_q, dout_ts_d;
  logic [IDw-1:0] ptr_q, ptr_d, gnt, idx, dout_id_q, dout_id_d;
  logic [Fpay-1:0] dout_q, dout_d;
  logic dout_valid_q, dout_valid_d, any, load;
  logic [DROP_CNTw-1:0] drop_q [Tile_num];
  logic [DROP_CNTw-1:0] drop_d [Tile_num];
  assign wen  = wr_all & ip_mask;
  assign push = wen & ~full;
  for (genvar g = 0; g < Tile_num; g++) begin : g_chan
    trace_chan_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .reset(reset), .push(push[g]), .pop(pop[g]),
      .din({ts_q, din_all[g*Fpay +: Fpay]}), .dout(fdata[g]),
      .full(full[g]), .empty(empty[g])
    );
    assign pop[g] = load && (gnt == IDw'(g));
    assign drop_cnt_all[g*DROP_CNTw +: DROP_CNTw] = drop_q[g];
  end
  // Scan from the highest offset down so the nearest non-empty channel after ptr wins
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = Tile_num - 1; k >= 0; k--) begin
      idx = IDw'((int'(ptr_q) + k) % Tile_num);
      if (!empty[idx]) begin
        gnt = idx;
        any = 1'b1;
      end
    end
  end
  always_comb begin
    load         = (!dout_valid_q || dout_ready) && any;
    ptr_d        = load ? ((gnt == IDw'(Tile_num - 1)) ? '0 : gnt + IDw'(1)) : ptr_q;
    dout_valid_d = load || (dout_valid_q && !dout_ready);
    dout_d       = load ? fdata[gnt][Fpay-1:0] : dout_q;
    dout_ts_d    = load ? fdata[gnt][TSL +: TSw] : dout_ts_q;
    dout_id_d    = load ? gnt : dout_id_q;
    ts_d         = ts_q + TSw'(1);
    for (int i = 0; i < Tile_num; i++)
      drop_d[i] = clear_drops ? '0 :
                  (wen[i] && full[i] && drop_q[i] != '1) ? drop_q[i] + DROP_CNTw'(1) : drop_q[i];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ts_q         <= '0;
      ptr_q        <= '0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      dout_id_q    <= '0;
      dout_ts_q    <= '0;
      drop_q       <= '{default: '0};
    end else begin
      ts_q         <= ts_d;
      ptr_q        <= ptr_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
      dout_id_q    <= dout_id_d;
      dout_ts_q    <= dout_ts_d;
      drop_q       <= drop_d;
    end
  assign dout       = dout_q;
  assign dout_id    = dout_id_q;
  assign dout_ts    = dout_ts_q;
  assign dout_valid = dout_valid_q;
endmodule

// File: tb/tb_trace_collector.sv
// tb_trace_collector: directed scenarios with an expected-output queue checked by a negedge monitor
`timescale 1ns/1ps
module tb_trace_collector;
  localparam int FP = 32, TN = 4, FD = 4, TW = 16, DW = 8, IW = 2;
  logic clk = 1'b0, reset = 1'b1;
  logic [TN*FP-1:0] din_all = '0;
  logic [TN-1:0] wr_all = '0, ip_mask = '1;
  logic [FP-1:0] dout;
  logic [IW-1:0] dout_id;
  logic [TW-1:0] dout_ts;
  logic dout_valid, dout_ready = 1'b1, clear_drops = 1'b0;
  logic [TN*DW-1:0] drop_cnt_all;
  typedef struct packed {logic [IW-1:0] id; logic [TW-1:0] ts; logic [FP-1:0] d;} exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int n_cmp = 0, n_bad = 0;
  logic [TW-1:0] m_ts;
  logic hold_v = 1'b0;
  logic [FP+IW+TW-1:0] held = '0;
  always #5 clk = ~clk;
  trace_collector #(.Fpay(FP), .Tile_num(TN), .FIFO_DEPTH(FD), .TSw(TW), .DROP_CNTw(DW)) dut (
    .clk(clk), .reset(reset), .din_all(din_all), .wr_all(wr_all), .ip_mask(ip_mask),
    .dout(dout), .dout_id(dout_id), .dout_ts(dout_ts), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .drop_cnt_all(drop_cnt_all), .clear_drops(clear_drops)
  );
  // Reference timestamp: value the DUT will stamp on a write sampled at the coming edge
  always @(posedge clk or posedge reset) m_ts <= reset ? '0 : m_ts + TW'(1);
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  function automatic logic [DW-1:0] dc(input int t);
    return drop_cnt_all[t*DW +: DW];
  endfunction
  always @(negedge clk) begin
    if (reset) hold_v <= 1'b0;
    else begin
      if (hold_v) chk("hold_stable", 64'({dout, dout_id, dout_ts}), 64'(held));
      if (dout_valid && dout_ready) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got id=%0d data=%h ts=%h, required no output", dout_id, dout, dout_ts);
        end else begin
          mon_e = sbq.pop_front();
          chk("out_data", 64'(dout), 64'(mon_e.d));
          chk("out_id", 64'(dout_id), 64'(mon_e.id));
          chk("out_ts", 64'(dout_ts), 64'(mon_e.ts));
        end
      end
      hold_v <= dout_valid && !dout_ready;
      held   <= {dout, dout_id, dout_ts};
    end
  end
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic issue(input int t, input logic [FP-1:0] d, input bit acc);
    din_all[t*FP +: FP] = d;
    wr_all[t] = 1'b1;
    if (acc) sbq.push_back(exp_t'{id: IW'(t), ts: m_ts, d: d});
    cyc(1);
    wr_all = '0;
  endtask
  task automatic drain(input int n);
    int c = 0;
    while ((sbq.size() != 0 || dout_valid) && c < n) begin
      cyc(1);
      c++;
    end
    chk("drain_left", 64'(sbq.size()), 64'd0);
    chk("drain_valid", 64'(dout_valid), 64'd0);
  endtask
  initial begin
    cyc(3);
    chk("rst_valid", 64'(dout_valid), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_id", 64'(dout_id), 64'd0);
    chk("rst_ts", 64'(dout_ts), 64'd0);
    chk("rst_drops", 64'(drop_cnt_all), 64'd0);
    reset = 1'b0;
    // single write at ts 0x0010
    for (int i = 0; i < 100 && m_ts != 16'h0010; i++) cyc(1);
    din_all[2*FP +: FP] = 32'hDEAD_BEEF;
    wr_all[2] = 1'b1;
    sbq.push_back(exp_t'{id: 2'd2, ts: 16'h0010, d: 32'hDEAD_BEEF});
    cyc(1);
    wr_all = '0;
    chk("lat_e0", 64'(dout_valid), 64'd0);
    cyc(1);
    chk("lat_e1", 64'(dout_valid), 64'd1);
    cyc(1);
    chk("one_cycle", 64'(dout_valid), 64'd0);
    drain(10);
    // round robin: last grant tile 1, then all four at once -> 2,3,0,1
    issue(1, 32'h1111_1111, 1);
    drain(10);
    for (int t = 0; t < TN; t++) din_all[t*FP +: FP] = 32'hC0DE_0000 + t;
    wr_all = '1;
    sbq.push_back(exp_t'{id: 2'd2, ts: m_ts, d: 32'hC0DE_0002});
    sbq.push_back(exp_t'{id: 2'd3, ts: m_ts, d: 32'hC0DE_0003});
    sbq.push_back(exp_t'{id: 2'd0, ts: m_ts, d: 32'hC0DE_0000});
    sbq.push_back(exp_t'{id: 2'd1, ts: m_ts, d: 32'hC0DE_0001});
    cyc(1);
    wr_all = '0;
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      chk("rr_back_to_back", 64'(dout_valid), 64'd1);
    end
    drain(10);
    // overflow on tile 0 while stalled
    chk("drop0_init", 64'(dc(0)), 64'd0);
    dout_ready = 1'b0;
    for (int k = 1; k <= 6; k++) issue(0, 32'hA0 + k, k <= 5);
    chk("ovf_drop", 64'(dc(0)), 64'd1);
    chk("ovf_head", 64'(dout), 64'hA1);
    chk("ovf_valid", 64'(dout_valid), 64'd1);
    dout_ready = 1'b1;
    drain(20);
    // mask: queued tile-2 word still drains, masked write vanishes
    dout_ready = 1'b0;
    issue(0, 32'hB000_0000, 1);
    issue(2, 32'hC100_0001, 1);
    ip_mask = 4'b1011;
    issue(2, 32'hC200_0002, 0);
    chk("mask_nodrop", 64'(dc(2)), 64'd0);
    dout_ready = 1'b1;
    drain(20);
    chk("mask_nodrop_after", 64'(dc(2)), 64'd0);
    ip_mask = '1;
    // saturation and clear on tile 3
    dout_ready = 1'b0;
    for (int n = 0; n < 305; n++) issue(3, 32'h3000_0000 + n, n < 5);
    chk("sat", 64'(dc(3)), 64'd255);
    clear_drops = 1'b1;
    issue(3, 32'h3FFF_0000, 0);
    clear_drops = 1'b0;
    chk("clear_wins", 64'(dc(3)), 64'd0);
    chk("clear_all", 64'(dc(0)), 64'd0);
    issue(3, 32'h3FFF_0001, 0);
    chk("post_clear", 64'(dc(3)), 64'd1);
    dout_ready = 1'b1;
    drain(20);
    // timestamp wrap
    for (int i = 0; i < 70000 && m_ts != 16'hFFFF; i++) cyc(1);
    sbq.push_back(exp_t'{id: 2'd0, ts: 16'hFFFF, d: 32'hF00D_0001});
    issue(0, 32'hF00D_0001, 0);
    sbq.push_back(exp_t'{id: 2'd0, ts: 16'h0000, d: 32'hF00D_0002});
    issue(0, 32'hF00D_0002, 0);
    drain(10);
    // asynchronous reset mid-stall
    dout_ready = 1'b0;
    issue(1, 32'hBAD0_0001, 1);
    cyc(1);
    chk("pre_rst_valid", 64'(dout_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", 64'(dout_valid), 64'd0);
    chk("async_rst_dout", 64'(dout), 64'd0);
    chk("async_rst_id", 64'(dout_id), 64'd0);
    chk("async_rst_ts", 64'(dout_ts), 64'd0);
    sbq.delete();
    din_all[FP +: FP] = 32'h600D_0001;
    wr_all[1] = 1'b1;
    sbq.push_back(exp_t'{id: 2'd1, ts: 16'h0000, d: 32'h600D_0001});
    @(negedge clk);
    #1 reset = 1'b0;
    cyc(1);
    wr_all = '0;
    dout_ready = 1'b1;
    drain(10);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
